// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared opcodes, ALU function codes, buffer state and entry types
package alu_operand_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_SR = 3'b101;

  // Encoding is {funct7[5], funct3} so R-type instructions map straight through.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_fn_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] lhs;
    logic [DATA_W-1:0] rhs;
    logic [3:0]        fn;
    logic [2:0]        compare_sel;
    logic              is_branch;
    logic              illegal;
  } op_entry_t;

  localparam op_entry_t OP_ENTRY_RESET = '0;

endpackage

// File: rtl/alu_operand_decode.sv
// rtl/alu_operand_decode.sv - combinational opcode decode into ALU operands and function
module alu_operand_decode
  import alu_operand_stage_pkg::*;
(
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc,
  output op_entry_t         entry
);

  always_comb begin
    entry = OP_ENTRY_RESET;
    case (opcode)
      OPC_OP: begin
        entry.lhs = rs1_data;
        entry.rhs = rs2_data;
        entry.fn  = {funct7b5, funct3};
      end
      OPC_OP_IMM: begin
        // Bit 30 of an immediate is only an opcode modifier for the shift-right pair.
        entry.lhs = rs1_data;
        entry.rhs = imm;
        entry.fn  = {(funct3 == F3_SR) && funct7b5, funct3};
      end
      OPC_LUI: begin
        entry.rhs = imm;
        entry.fn  = ALU_ADD;
      end
      OPC_AUIPC: begin
        entry.lhs = pc;
        entry.rhs = imm;
        entry.fn  = ALU_ADD;
      end
      OPC_JAL, OPC_JALR: begin
        entry.lhs = pc;
        entry.rhs = DATA_W'(4);
        entry.fn  = ALU_ADD;
      end
      OPC_LOAD, OPC_STORE: begin
        entry.lhs = rs1_data;
        entry.rhs = imm;
        entry.fn  = ALU_ADD;
      end
      OPC_BRANCH: begin
        entry.lhs         = rs1_data;
        entry.rhs         = rs2_data;
        entry.fn          = ALU_SUB;
        entry.is_branch   = 1'b1;
        entry.compare_sel = funct3;
      end
      default: begin
        entry.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - two-entry (main + skid) operand buffer between decode and the ALU
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] lhs,
  output logic [XLEN-1:0] rhs,
  output logic [3:0]      alu_function,
  output logic [2:0]      compare_sel,
  output logic            is_branch,
  output logic            illegal
);

  op_entry_t  dec_entry;
  buf_state_e state_q, state_d;
  op_entry_t  main_q, main_d;
  op_entry_t  skid_q, skid_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;
  logic       emit;

  alu_operand_decode u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .imm      (imm),
    .pc       (pc),
    .entry    (dec_entry)
  );

  assign accept = in_valid && in_ready_q;
  assign emit   = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          main_d  = dec_entry;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && emit) begin
          main_d = dec_entry;
        end else if (accept) begin
          skid_d  = dec_entry;
          state_d = BUF_TWO;
        end else if (emit) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = BUF_EMPTY;
    end
    // Handshake flags are registered from the next state so neither port sees a combinational path.
    in_ready_d  = (state_d != BUF_TWO);
    out_valid_d = (state_d != BUF_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BUF_EMPTY;
      main_q      <= OP_ENTRY_RESET;
      skid_q      <= OP_ENTRY_RESET;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign lhs          = main_q.lhs;
  assign rhs          = main_q.rhs;
  assign alu_function = main_q.fn;
  assign compare_sel  = main_q.compare_sel;
  assign is_branch    = main_q.is_branch;
  assign illegal      = main_q.illegal;

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 InValid  input  1  upstream (decode) presents an instruction.
REQ-005 InReady  output  1  stage can accept an instruction this cycle.
REQ-006 Opcode  input  7  instruction bits [6:0].
REQ-007 Funct3  input  3  instruction bits [14:12].
REQ-008 Funct7b5  input  1  instruction bit 30.
REQ-009 Rs1Data, Rs2Data, Imm, PC  input  XLEN each  register operands, sign-extended immediate, instruction address.
REQ-010 Flush  input  1  discard all held and incoming instructions.
REQ-011 OutValid  output  1  LHS/RHS/Function hold a valid operation.
REQ-012 OutReady  input  1  downstream (ALU/execute) consumes the operation.
REQ-013 LHS, RHS  output  XLEN each  ALU operands; Function  output  4  ALU function code.
REQ-014 CompareSel  output  3  branch condition index (Funct3); IsBranch  output  1; Illegal  output  1  unsupported opcode.

Function
REQ-015 ALU codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-016 OP (0110011): LHS=Rs1Data, RHS=Rs2Data, Function={Funct7b5,Funct3}.
REQ-017 OP-IMM (0010011): LHS=Rs1Data, RHS=Imm, Function={Funct7b5 only when Funct3=101, else 0; Funct3}.
REQ-018 LUI (0110111): LHS=0, RHS=Imm, ADD; AUIPC (0010111): LHS=PC, RHS=Imm, ADD.
REQ-019 JAL (1101111)/JALR (1100111): LHS=PC, RHS=4, ADD (link value).
REQ-020 LOAD (0000011)/STORE (0100011): LHS=Rs1Data, RHS=Imm, ADD.
REQ-021 BRANCH (1100011): LHS=Rs1Data, RHS=Rs2Data, SUB, IsBranch=1, CompareSel=Funct3; IsBranch=0 for all other opcodes.
REQ-022 Any other opcode: LHS=RHS=0, Function=0000, Illegal=1; the entry still flows through the handshake.
REQ-023 Transfer in when InValid&&InReady; transfer out when OutValid&&OutReady.
REQ-024 Latency: an accepted instruction appears on outputs the next cycle when the stage was empty or draining.
REQ-025 Two-entry buffer (main + skid); states EMPTY, ONE, TWO; InReady=1 in EMPTY and ONE, 0 in TWO, driven from a register.
REQ-026 EMPTY: in -> ONE. ONE: in&&!out -> TWO; out&&!in -> EMPTY; both or neither -> ONE (main replaced on both).
REQ-027 TWO: out -> ONE with skid moved to main; otherwise hold.
REQ-028 Outputs always reflect the main entry; outputs hold stable while OutValid&&!OutReady.
REQ-029 Order is strictly preserved; no entry is duplicated or dropped except by Flush/Reset.
REQ-030 Flush: next state EMPTY, same-cycle input discarded, OutValid=0 next cycle; Flush overrides simultaneous transfers.

Reset
REQ-031 Reset: state EMPTY, OutValid=0, InReady=1, LHS=RHS=0, Function=0000, CompareSel=0, IsBranch=0, Illegal=0.
REQ-032 Reset mid-operation discards all buffered entries; Reset has priority over Flush and all handshakes.

Structure
REQ-033 Shared package holds opcode constants, ALU function codes, and the buffer state enum; the ALU uses the same function codes.
REQ-034 Combinational decode is one sub-module, alu_operand_decode; alu_operand_stage holds the buffer and FSM only.

Verification
REQ-035 ADD: OP, Funct3=000, Funct7b5=0, Rs1=5, Rs2=7, OutReady=1 -> next cycle OutValid=1, LHS=5, RHS=7, Function=0000.
REQ-036 SRAI vs ADDI: OP-IMM Funct3=101, b5=1 -> Function=1101; Funct3=000, b5=1 -> Function=0000.
REQ-037 Backpressure: OutReady=0, three InValid cycles -> InReady low after two accepts, outputs frozen; OutReady=1 -> both emitted in order.
REQ-038 BEQ at PC=0x100, Rs1=Rs2=3 -> LHS=3, RHS=3, Function=1000, IsBranch=1, CompareSel=000; JAL at PC=0x100 -> LHS=0x100, RHS=4.
REQ-039 Flush in state TWO with InValid=1 -> next cycle OutValid=0, InReady=1, nothing emitted afterward.
REQ-040 Opcode 1111111 -> Illegal=1, Function=0000; Reset asserted mid-stream -> all outputs at REQ-031 values next cycle.
